// File: rtl/ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx -- PS/2 device-to-host frame receiver
//
// Receives the 11-bit PS/2 frame (start 0, 8 data bits LSB first, odd parity,
// stop 1). The PS/2 clock is debounced by a shift-register filter; the data
// line is sampled on each filtered falling edge. A watchdog aborts a frame
// whose clock stalls for too long inside the frame.
//
// Parameters
//   FILTER_LEN   consecutive equal ps2c samples needed to change the
//                filtered clock level
//   TIMEOUT_CYC  maximum clk cycles allowed between falling edges in a frame
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-low reset
//   ps2c, ps2d    PS/2 clock/data, already synchronized to clk
//   rx_en         high permits a new frame to start (does not abort a frame)
//   dout          last received data byte (held between ticks)
//   rx_done_tick  one-cycle pulse when a frame completes
//   parity_err    odd parity failed for the frame in dout
//   frame_err     stop bit was 0 for the frame in dout
//   timeout_tick  one-cycle pulse when the watchdog aborts a frame
// ---------------------------------------------------------------------------
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err,
    output logic       timeout_tick
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        LOAD = 2'd2
    } state_t;

    // High when the 9 bits (data + parity) contain an even number of ones,
    // i.e. the odd-parity check failed.
    function automatic logic odd_parity_fail(input logic [8:0] v);
        return ~(^v);
    endfunction

    // Registered state
    logic [FILTER_LEN-1:0] filt_r;
    logic                  fclk_r;
    state_t                state_r;
    logic [3:0]            cnt_r;
    logic [WD_W-1:0]       wd_r;
    logic [9:0]            shift_r;
    logic [7:0]            dout_r;
    logic                  perr_r;
    logic                  ferr_r;
    logic                  done_r;
    logic                  tmo_r;

    // Next-state / combinational signals
    logic [FILTER_LEN-1:0] filt_next_s;
    logic                  fclk_next_s;
    logic                  fall_edge_s;
    state_t                state_next_s;
    logic [3:0]            cnt_next_s;
    logic [WD_W-1:0]       wd_next_s;
    logic [9:0]            shift_next_s;
    logic                  load_s;
    logic                  tmo_s;

    // Glitch filter: the filtered clock only moves once the whole sample
    // window agrees, so a short glitch never produces an edge.
    always_comb begin
        filt_next_s = {ps2c, filt_r[FILTER_LEN-1:1]};
        fclk_next_s = fclk_r;
        if (&filt_r) begin
            fclk_next_s = 1'b1;
        end else if (~|filt_r) begin
            fclk_next_s = 1'b0;
        end else begin
            fclk_next_s = fclk_r;
        end
        fall_edge_s = fclk_r & ~fclk_next_s;
    end

    // Frame FSM next-state logic, bit counter, shifter and watchdog.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        wd_next_s    = wd_r;
        shift_next_s = shift_r;
        load_s       = 1'b0;
        tmo_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (fall_edge_s && rx_en && !ps2d) begin
                    state_next_s = DATA;
                    cnt_next_s   = 4'd10;
                    wd_next_s    = {WD_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            DATA: begin
                // An edge arriving in the same cycle as the watchdog limit
                // takes priority, so it is tested first.
                if (fall_edge_s) begin
                    shift_next_s = {ps2d, shift_r[9:1]};
                    cnt_next_s   = cnt_r - 4'd1;
                    wd_next_s    = {WD_W{1'b0}};
                    if (cnt_r == 4'd1) begin
                        state_next_s = LOAD;
                        load_s       = 1'b1;
                    end else begin
                        state_next_s = DATA;
                    end
                end else if (wd_r == WD_LIMIT) begin
                    state_next_s = IDLE;
                    wd_next_s    = {WD_W{1'b0}};
                    tmo_s        = 1'b1;
                end else begin
                    wd_next_s = wd_r + WD_W'(1);
                end
            end
            LOAD: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, filter and output registers. The result is captured on the
    // stop-bit edge so that dout/flags/rx_done_tick are valid together
    // during the single LOAD cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filt_r  <= {FILTER_LEN{1'b1}};
            fclk_r  <= 1'b1;
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            wd_r    <= {WD_W{1'b0}};
            shift_r <= 10'd0;
            dout_r  <= 8'h00;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            done_r  <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            filt_r  <= filt_next_s;
            fclk_r  <= fclk_next_s;
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            wd_r    <= wd_next_s;
            shift_r <= shift_next_s;
            done_r  <= load_s;
            tmo_r   <= tmo_s;
            if (load_s) begin
                dout_r <= shift_next_s[7:0];
                perr_r <= odd_parity_fail(shift_next_s[8:0]);
                ferr_r <= ~shift_next_s[9];
            end else begin
                dout_r <= dout_r;
                perr_r <= perr_r;
                ferr_r <= ferr_r;
            end
        end
    end

    assign dout         = dout_r;
    assign rx_done_tick = done_r;
    assign parity_err   = perr_r;
    assign frame_err    = ferr_r;
    assign timeout_tick = tmo_r;

endmodule

// File: tb/tb_ps2_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_rx -- table-driven bench for ps2_rx
// A PS/2 device model drives frames with a 40-clk half period. A table of
// frames with hand-computed results is replayed, followed by hand-written
// sequences for glitch rejection, watchdog timeout and mid-frame reset.
// ---------------------------------------------------------------------------
module tb_ps2_rx;

    localparam int FLEN = 8;
    localparam int TMO  = 200;
    localparam int HP   = 40;
    // Drive of ps2c low -> 8 samples to fill the filter -> 1 cycle to register.
    localparam int LAT_DONE = FLEN + 1;
    localparam int LAT_TMO  = FLEN + 1 + TMO;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       parity_err;
    logic       frame_err;
    logic       timeout_tick;

    ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .rx_en        (rx_en),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .timeout_tick (timeout_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts every cycle a tick is seen high.
    int done_cnt = 0, tmo_cnt = 0, done_cyc = 0, tmo_cyc = 0;
    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (timeout_tick === 1'b1) begin
            tmo_cnt <= tmo_cnt + 1;
            tmo_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int last_fall_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One PS/2 bit: data changes while clock is high, then a 40-clk low phase.
    // Fall-to-fall spacing is hi_pre + 61 cycles (80 for hi_pre = 19).
    task automatic ps2_bit(input logic b, input int hi_pre);
        @(negedge clk);
        ps2d = b;
        repeat (hi_pre) @(negedge clk);
        ps2c = 1'b0;
        last_fall_cyc = cyc;
        repeat (HP) @(negedge clk);
        ps2c = 1'b1;
        repeat (HP / 2) @(negedge clk);
    endtask

    // Sends the first n bits of an 11-bit frame (bit 0 = start).
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) ps2_bit(bits[i], 19);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic en_start, input logic en_rest,
                              input int stretch_bit, input int stretch_hi);
        logic [10:0] bits;
        bits  = {stop, par, d, 1'b0};
        rx_en = en_start;
        ps2_bit(bits[0], 19);
        rx_en = en_rest;
        for (int i = 1; i < 11; i++)
            ps2_bit(bits[i], (i - 1 == stretch_bit) ? stretch_hi : 19);
        ps2d = 1'b1;
        repeat (30) @(negedge clk);
        rx_en = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stop;
        logic       en_start;
        logic       en_rest;
        int         stretch_bit;
        int         stretch_hi;
        int         exp_ticks;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int d0, t0;
        // data, par, stop, en_start, en_rest, stretch_bit, stretch_hi, ticks, dout, perr, ferr
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1, -1, 19, 1, 8'h1C, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 19, 1, 8'h1C, 1'b1, 1'b0};
        vecs[2] = '{8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, -1, 19, 1, 8'hF0, 1'b0, 1'b1};
        // rx_en low across the start bit: ignored, previous outputs held
        vecs[3] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, -1, 19, 0, 8'hF0, 1'b0, 1'b1};
        // rx_en dropped after the start bit: frame still completes
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, -1, 19, 1, 8'hA5, 1'b0, 1'b0};
        // edge lands in the very cycle the watchdog hits its limit (200 spacing)
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 5, 139, 1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, -1, 19, 1, 8'hFF, 1'b1, 1'b1};
        vecs[7] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1, 19, 1, 8'h3C, 1'b0, 1'b0};

        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_perr", parity_err, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_done", rx_done_tick, 1'b0);
        check("reset_tmo", timeout_tick, 1'b0);

        // Table of frames
        foreach (vecs[k]) begin
            d0 = done_cnt;
            t0 = tmo_cnt;
            send_frame(vecs[k].d, vecs[k].par, vecs[k].stop, vecs[k].en_start,
                       vecs[k].en_rest, vecs[k].stretch_bit, vecs[k].stretch_hi);
            check($sformatf("v%0d_ticks", k), done_cnt - d0, vecs[k].exp_ticks);
            check($sformatf("v%0d_tmo", k), tmo_cnt - t0, 0);
            check($sformatf("v%0d_dout", k), dout, vecs[k].exp_dout);
            check($sformatf("v%0d_perr", k), parity_err, vecs[k].exp_perr);
            check($sformatf("v%0d_ferr", k), frame_err, vecs[k].exp_ferr);
            if (vecs[k].exp_ticks == 1)
                check($sformatf("v%0d_latency", k), done_cyc - last_fall_cyc, LAT_DONE);
        end

        // Glitch: 3-cycle low on idle ps2c with ps2d low must not start a frame
        d0 = done_cnt;
        t0 = tmo_cnt;
        ps2d = 1'b0;
        @(negedge clk);
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (TMO + 100) @(negedge clk);
        ps2d = 1'b1;
        check("glitch_ticks", done_cnt - d0, 0);
        check("glitch_tmo", tmo_cnt - t0, 0);

        // Watchdog: start + 5 data bits of 0x3C, then ps2c stops
        d0 = done_cnt;
        t0 = tmo_cnt;
        send_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 6);
        for (int i = 0; i < 2 * TMO && tmo_cnt == t0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("tmo_ticks", tmo_cnt - t0, 1);
        check("tmo_latency", tmo_cyc - last_fall_cyc, LAT_TMO);
        check("tmo_no_done", done_cnt - d0, 0);
        check("tmo_dout_held", dout, 8'h3C);
        d0 = done_cnt;
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, -1, 19);
        check("after_tmo_ticks", done_cnt - d0, 1);
        check("after_tmo_dout", dout, 8'h5A);

        // Reset after 4 data bits of 0x29, then a full 0x29 frame
        d0 = done_cnt;
        t0 = tmo_cnt;
        send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (TMO + 50) @(negedge clk);
        check("rst_mid_dout", dout, 8'h00);
        check("rst_mid_ticks", done_cnt - d0, 0);
        check("rst_mid_tmo", tmo_cnt - t0, 0);
        send_frame(8'h29, 1'b0, 1'b1, 1'b1, 1'b1, -1, 19);
        check("post_rst_ticks", done_cnt - d0, 1);
        check("post_rst_dout", dout, 8'h29);
        check("post_rst_perr", parity_err, 1'b0);
        check("post_rst_ferr", frame_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
